pend_encoder: RTL

Registered, parametrised N-to-log2(N) request encoder with sticky pending capture, fixed-priority or round-robin selection, and a valid/ready output handshake. Request pulses on any subset of N lines are latched, then emitted one index at a time until every latched request has been accepted. It sits between raw one-hot/multi-hot event sources and any consumer that takes a single encoded index per transfer. It replaces the purely combinational 16-to-4 encoder, which had no storage or flow control.

---
 rtl/pend_encoder.sv | 104 ++++++++++
 1 files changed

// File: rtl/pend_encoder.sv
// Sticky pending-request capture; emits one encoded index per valid/ready transfer.
// Latency: req_in pulse to out_valid is 2 edges from idle; one index per cycle back-to-back.
// Backpressure: out_idx frozen while out_ready is low; new requests keep accumulating in pend.
module pend_encoder #(
    parameter int N = 16,
    parameter bit RR = 1'b0,
    localparam int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req_in,
    input  logic             out_ready,
    input  logic             ovf_clr,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_valid,
    output logic [N-1:0]     pend,
    output logic [IDX_W:0]   pend_cnt,
    output logic             overflow
);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [IDX_W-1:0] idx_d;
    logic [IDX_W-1:0] sel_idx;
    logic [IDX_W-1:0] pos;
    logic             sel_any;
    logic             load;
    logic             accept;
    logic             ovf_evt;
    logic [N-1:0]     clr_mask;
    logic [N-1:0]     sel_src;
    logic [N-1:0]     pend_next;

    assign out_valid = (state_q == HOLD);
    assign accept    = out_valid & out_ready;
    assign clr_mask  = accept ? (N'(1) << out_idx) : '0;
    assign sel_src   = pend & ~clr_mask;
    assign pend_next = sel_src | req_in;
    // A re-request on the bit being accepted is a fresh request, not an overflow.
    assign ovf_evt   = |(req_in & sel_src);

    // Scan in reverse search order so the first hit in search order is the last write.
    always_comb begin
        sel_idx = '0;
        pos     = '0;
        sel_any = |sel_src;
        for (int i = N - 1; i >= 0; i--) begin
            if (RR) begin
                pos = IDX_W'((int'(last_q) + 1 + i) % N);
            end else begin
                pos = IDX_W'(i);
            end
            if (sel_src[pos]) begin
                sel_idx = pos;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (sel_any) begin
                    load    = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (accept) begin
                    if (sel_any) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        idx_d  = load ? sel_idx : out_idx;
        last_d = load ? sel_idx : last_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            out_idx  <= '0;
            last_q   <= IDX_W'(N - 1);
            pend     <= '0;
            pend_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            state_q  <= state_d;
            out_idx  <= idx_d;
            last_q   <= last_d;
            pend     <= pend_next;
            pend_cnt <= (IDX_W + 1)'($countones(pend_next));
            overflow <= ovf_evt | (overflow & ~ovf_clr);
        end
    end

endmodule
